// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle logarithmic barrel shifter, one mux stage reused
// over S = $clog2(N) cycles.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_data  [N-1:0]    operand
//   in_shamt [S-1:0]    shift amount
//   in_op    [1:0]      00 SRL, 01 SLL, 10 SRA, 11 ROR
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   out_data [N-1:0]    working register, visible in every state
//
// Build option: define SHIFTER_SEQ_ROTATE_EN to build the rotate path.
// Without it op 11 is a logical right shift.

// Per-lane stage mux: picks the candidate of the active stage, or holds.
module shifter_seq_lane #(
  parameter int S = 5
) (
  input  logic         cur,
  input  logic [S-1:0] stg_on,
  input  logic [S-1:0] rc,
  input  logic [S-1:0] lc,
`ifdef SHIFTER_SEQ_ROTATE_EN
  input  logic [S-1:0] oc,
  input  logic         ror,
`endif
  input  logic         left,
  output logic         y
);
  always_comb begin
    y = cur;
    for (int kk = 0; kk < S; kk++) begin
      if (stg_on[kk]) begin
`ifdef SHIFTER_SEQ_ROTATE_EN
        if (ror) y = oc[kk];
        else
`endif
        y = left ? lc[kk] : rc[kk];
      end
    end
  end
endmodule

module shifter_seq #(
  parameter int N = 32,
  parameter int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_shamt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [S-1:0] KLAST = S'(S - 1);

  state_t       state;
  logic [N-1:0] work, nxt;
  logic [S-1:0] shamt, k, stg_on;
  logic [1:0]   op;
  logic         sign, left, fill;

  assign left = (op == 2'b01);
  // Sign is taken from the operand at accept, not from the shifting register.
  assign fill = (op == 2'b10) & sign;

`ifdef SHIFTER_SEQ_ROTATE_EN
  logic ror;
  assign ror = (op == 2'b11);
`endif

  // One-hot enable: stage k is live only if its shamt bit is set.
  for (genvar kk = 0; kk < S; kk++) begin : g_on
    assign stg_on[kk] = shamt[kk] && (k == S'(kk));
  end

  // Candidate bits per lane and stage; distance 2^kk is constant here, so
  // out-of-range sources collapse to the fill value at elaboration.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [S-1:0] rc, lc;
`ifdef SHIFTER_SEQ_ROTATE_EN
    logic [S-1:0] oc;
`endif
    for (genvar kk = 0; kk < S; kk++) begin : g_stg
      localparam int A = 1 << kk;
      if (i + A < N) begin : g_rin
        assign rc[kk] = work[i + A];
      end else begin : g_rout
        assign rc[kk] = fill;
      end
      if (i >= A) begin : g_lin
        assign lc[kk] = work[i - A];
      end else begin : g_lout
        assign lc[kk] = 1'b0;
      end
`ifdef SHIFTER_SEQ_ROTATE_EN
      // Rotate distance wraps modulo N for non-power-of-two widths.
      assign oc[kk] = work[(i + (A % N)) % N];
`endif
    end

    shifter_seq_lane #(.S(S)) u_lane (
      .cur    (work[i]),
      .stg_on (stg_on),
      .rc     (rc),
      .lc     (lc),
`ifdef SHIFTER_SEQ_ROTATE_EN
      .oc     (oc),
      .ror    (ror),
`endif
      .left   (left),
      .y      (nxt[i])
    );
  end

  assign in_ready = (state == IDLE);
  assign out_data = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      work      <= '0;
      shamt     <= '0;
      op        <= '0;
      sign      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          shamt <= in_shamt;
          op    <= in_op;
          sign  <= in_data[N-1];
          k     <= '0;
          state <= BUSY;
        end
        // No early-out: all S stages run even when shamt is zero.
        BUSY: begin
          work <= nxt;
          if (k == KLAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
